// File: rtl/pram_sram_pattern_seq.sv
// Pattern-ROM driven write-all / read-all / compare sequencer for a word-wide memory port.
// Each pass rotates the ROM index by one so every word sees a different pattern per pass.
//
// state  | meaning
// IDLE   | waiting for start after reset
// W_ROM  | load rom_addr for the word about to be written
// W_WAIT | ROM address register latency
// W_REQ  | latch ROM word into mem_wdata, then hold write request until ack
// R_ROM  | load rom_addr for the word about to be read
// R_WAIT | ROM address register latency
// R_REQ  | latch expected word, then hold read request until ack
// CHECK  | compare read word, update error status, advance word/pass
// DONE   | run finished, status valid until next start
module pram_sram_pattern_seq #(
    parameter int ADDR_WIDTH = 18,
    parameter int TEST_WORDS = 256,
    parameter int NUM_PASSES = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [5:0]            pass_num_o,
    output logic [5:0]            rom_addr_o,
    input  logic [15:0]           rom_data_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [15:0]           mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [15:0]           mem_rdata_i,
    output logic [15:0]           err_count_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o,
    output logic [15:0]           first_err_exp_o,
    output logic [15:0]           first_err_act_o
);

    typedef enum logic [3:0] {
        IDLE, W_ROM, W_WAIT, W_REQ, R_ROM, R_WAIT, R_REQ, CHECK, DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(TEST_WORDS - 1);
    localparam logic [5:0]            LAST_PASS = 6'(NUM_PASSES - 1);

    state_t                  state_q;
    logic                    busy_q, done_q, pass_q;
    logic [5:0]              pass_num_q, rom_addr_q;
    logic [ADDR_WIDTH-1:0]   word_q;
    logic                    mem_req_q, mem_we_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [15:0]             mem_wdata_q;
    logic [15:0]             exp_q, act_q;
    logic [15:0]             err_count_q;
    logic [ADDR_WIDTH-1:0]   first_err_addr_q;
    logic [15:0]             first_err_exp_q, first_err_act_q;

    logic [5:0]              rom_idx_d;
    logic                    mismatch_d;
    logic [15:0]             err_count_d;

    always_comb begin
        rom_idx_d   = word_q[5:0] + pass_num_q;
        mismatch_d  = (act_q != exp_q);
        err_count_d = err_count_q;
        if (mismatch_d && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q          <= IDLE;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            pass_num_q       <= '0;
            rom_addr_q       <= '0;
            word_q           <= '0;
            mem_req_q        <= 1'b0;
            mem_we_q         <= 1'b0;
            mem_addr_q       <= '0;
            mem_wdata_q      <= '0;
            exp_q            <= '0;
            act_q            <= '0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
            first_err_exp_q  <= '0;
            first_err_act_q  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        busy_q           <= 1'b1;
                        done_q           <= 1'b0;
                        pass_q           <= 1'b0;
                        pass_num_q       <= '0;
                        word_q           <= '0;
                        err_count_q      <= '0;
                        first_err_addr_q <= '0;
                        first_err_exp_q  <= '0;
                        first_err_act_q  <= '0;
                        state_q          <= W_ROM;
                    end
                end
                W_ROM: begin
                    rom_addr_q <= rom_idx_d;
                    state_q    <= W_WAIT;
                end
                W_WAIT: state_q <= W_REQ;
                W_REQ: begin
                    // First cycle: the ROM word is valid now, so latch it before raising the request.
                    if (!mem_req_q) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= word_q;
                        mem_wdata_q <= rom_data_i;
                    end else if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        if (word_q == LAST_WORD) begin
                            word_q  <= '0;
                            state_q <= R_ROM;
                        end else begin
                            word_q  <= word_q + 1'b1;
                            state_q <= W_ROM;
                        end
                    end
                end
                R_ROM: begin
                    rom_addr_q <= rom_idx_d;
                    state_q    <= R_WAIT;
                end
                R_WAIT: state_q <= R_REQ;
                R_REQ: begin
                    if (!mem_req_q) begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= word_q;
                        exp_q      <= rom_data_i;
                    end else if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        act_q     <= mem_rdata_i;
                        state_q   <= CHECK;
                    end
                end
                CHECK: begin
                    err_count_q <= err_count_d;
                    if (mismatch_d && (err_count_q == 16'd0)) begin
                        first_err_addr_q <= word_q;
                        first_err_exp_q  <= exp_q;
                        first_err_act_q  <= act_q;
                    end
                    if (word_q != LAST_WORD) begin
                        word_q  <= word_q + 1'b1;
                        state_q <= R_ROM;
                    end else if (pass_num_q != LAST_PASS) begin
                        pass_num_q <= pass_num_q + 6'd1;
                        word_q     <= '0;
                        state_q    <= W_ROM;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_count_d == 16'd0);
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign pass_num_o       = pass_num_q;
    assign rom_addr_o       = rom_addr_q;
    assign mem_req_o        = mem_req_q;
    assign mem_we_o         = mem_we_q;
    assign mem_addr_o       = mem_addr_q;
    assign mem_wdata_o      = mem_wdata_q;
    assign err_count_o      = err_count_q;
    assign first_err_addr_o = first_err_addr_q;
    assign first_err_exp_o  = first_err_exp_q;
    assign first_err_act_o  = first_err_act_q;

endmodule

// File: tb/tb_pram_sram_pattern_seq.sv
// Bench for pram_sram_pattern_seq: walking-one ROM model, configurable-latency memory model
// and a scoreboard of expected memory transactions.
module tb_pram_sram_pattern_seq;

    localparam int AW = 8;
    localparam int TW = 64;
    localparam int NP = 2;

    logic          clk = 1'b0;
    logic          reset, start;
    logic          busy, done, pass;
    logic [5:0]    pass_num, rom_addr;
    logic [15:0]   rom_data;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata, mem_rdata;
    logic [15:0]   err_count, first_err_exp, first_err_act;
    logic [AW-1:0] first_err_addr;

    int errors = 0;
    int checks = 0;

    int          ack_delay = 0;
    logic [15:0] rd_mask = 16'hFFFF;
    int          wait_cnt = 0;
    logic [15:0] mem_arr [0:255];

    logic [24:0] sb_q [$];
    int          hold_len = 0;
    logic [24:0] held;

    always #5 clk = ~clk;

    pram_sram_pattern_seq #(.ADDR_WIDTH(AW), .TEST_WORDS(TW), .NUM_PASSES(NP)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start),
        .busy_o(busy), .done_o(done), .pass_o(pass), .pass_num_o(pass_num),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
        .err_count_o(err_count), .first_err_addr_o(first_err_addr),
        .first_err_exp_o(first_err_exp), .first_err_act_o(first_err_act)
    );

    function automatic logic [15:0] pat(input int idx);
        return 16'h8000 >> ((idx % 64) % 16);
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ROM registers its address internally: data follows rom_addr by one edge.
    always @(posedge clk) rom_data <= pat(int'(rom_addr));

    assign mem_ack   = mem_req && (wait_cnt == ack_delay);
    assign mem_rdata = mem_arr[mem_addr] & rd_mask;

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
        if (mem_ack && mem_we) mem_arr[mem_addr] <= mem_wdata;
    end

    always @(negedge clk) begin
        if (!mem_req) begin
            hold_len = 0;
        end else begin
            hold_len++;
            if (hold_len == 1) held = {mem_we, mem_addr, mem_wdata};
            else chk("req_stable", {7'd0, mem_we, mem_addr, mem_wdata}, {7'd0, held});
            if (mem_ack) begin
                chk("req_hold_len", hold_len, ack_delay + 1);
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", sb_q.size(), 1);
                end else begin
                    logic [24:0] e;
                    e = sb_q.pop_front();
                    chk("txn_we", mem_we, e[24]);
                    chk("txn_addr", mem_addr, e[23:16]);
                    if (e[24]) chk("txn_wdata", mem_wdata, e[15:0]);
                    if (mem_we && pass_num == 6'd1 && mem_addr == 8'd63)
                        chk("wrap_word63_pass1", mem_wdata, 16'h8000);
                end
                hold_len = 0;
            end
        end
    end

    task automatic sb_push_run();
        for (int p = 0; p < NP; p++) begin
            for (int i = 0; i < TW; i++) sb_q.push_back({1'b1, 8'(i), pat(i + p)});
            for (int i = 0; i < TW; i++) sb_q.push_back({1'b0, 8'(i), 16'h0000});
        end
    endtask

    task automatic run(input int budget, input bit poke, output int cycles);
        bit poked;
        sb_push_run();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_after_start", done, 0);
        chk("pass_after_start", pass, 0);
        chk("err_after_start", err_count, 0);
        chk("ferr_addr_after_start", first_err_addr, 0);
        cycles = 0;
        poked  = 1'b0;
        while (!done && cycles < budget) begin
            @(posedge clk); cycles++; #1;
            if (poke && !poked && pass_num == 6'd1) begin
                start = 1'b1;
                @(posedge clk); cycles++; #1;
                start = 1'b0;
                poked = 1'b1;
                chk("pass_num_busy_start", pass_num, 1);
                chk("busy_busy_start", busy, 1);
            end
        end
        if (!done) chk("run_timeout", cycles, budget + 1);
        chk("busy_at_done", busy, 0);
        chk("pass_num_at_done", pass_num, NP - 1);
        chk("sb_empty", sb_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy_with_start", busy, 0);
        @(negedge clk); reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_pass_num", pass_num, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_ferr_addr", first_err_addr, 0);
        chk("rst_ferr_exp", first_err_exp, 0);
        chk("rst_ferr_act", first_err_act, 0);

        // Ideal memory: 4 cycles per write, 5 per read.
        ack_delay = 0; rd_mask = 16'hFFFF;
        run(5000, 1'b0, n);
        chk("ideal_cycles", n, NP * TW * 9);
        chk("ideal_done", done, 1);
        chk("ideal_pass", pass, 1);
        chk("ideal_err", err_count, 0);

        // Bit0 stuck at 0 on reads; a start while busy must be ignored.
        rd_mask = 16'hFFFE;
        run(5000, 1'b1, n);
        chk("stuck_done", done, 1);
        chk("stuck_pass", pass, 0);
        chk("stuck_err", err_count, 8);
        chk("stuck_ferr_addr", first_err_addr, 15);
        chk("stuck_ferr_exp", first_err_exp, 16'h0001);
        chk("stuck_ferr_act", first_err_act, 16'h0000);

        // Slow memory: ack in the 5th request cycle.
        rd_mask = 16'hFFFF; ack_delay = 4;
        run(10000, 1'b0, n);
        chk("slow_done", done, 1);
        chk("slow_pass", pass, 1);
        chk("slow_err", err_count, 0);

        // Reset in the middle of a write request.
        ack_delay = 2;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!(mem_req && mem_we) && n < 100) begin @(negedge clk); n++; end
        chk("reach_w_req", mem_req && mem_we, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err", err_count, 0);
        chk("midrst_pass_num", pass_num, 0);
        @(negedge clk); reset = 1'b0;
        sb_q.delete();
        @(negedge clk);
        ack_delay = 0;
        run(5000, 1'b0, n);
        chk("rerun_cycles", n, NP * TW * 9);
        chk("rerun_pass", pass, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
